// File: rtl/banked_regfile.sv
// banked_regfile
// Banked register file with a per-bank PC and CR and a trap/return sequencer.
// It holds NBANK banks of NREG registers. Index 0 of every bank reads as zero,
// and register PC_IDX of each bank is that bank's program counter. Bank
// NBANK-1 is the system bank: a trap enters it and an rti leaves it. All
// state changes on the falling edge of clk.
//
// Ports
//   clk                clock (state updates on the falling edge)
//   reset              asynchronous active-low reset
//   rd0_sel / rd0_data read port 0 index / data, current bank (combinational)
//   rd1_sel / rd1_data read port 1 index / data, current bank (combinational)
//   wr_en, wr_sel      register write enable and index
//   wr_data            register write data
//   incr_pc            advance the current-bank PC by PC_INC
//   cr_we, cr_wdata    current-bank CR write enable and data
//   cr_rdata           current-bank CR (combinational)
//   trap_req           enter the system bank (ignored when already there)
//   rti                return to the interrupted bank (only honoured in system bank)
//   cur_bank           active bank
//   pc                 current-bank PC (combinational)
module banked_regfile #(
  parameter int              DW       = 16,
  parameter int              NREG     = 8,
  parameter int              NBANK    = 2,
  parameter int              PC_IDX   = 7,
  parameter int              PC_INC   = 2,
  parameter logic [DW-1:0]   IVEC     = 16'h4,
  parameter logic [DW-1:0]   CR_INIT  = 16'h8,
  parameter logic [DW-1:0]   SCR_INIT = 16'h2,
  localparam int             AW       = $clog2(NREG),
  localparam int             BW       = (NBANK > 2) ? $clog2(NBANK) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rd0_sel,
  input  logic [AW-1:0] rd1_sel,
  output logic [DW-1:0] rd0_data,
  output logic [DW-1:0] rd1_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_sel,
  input  logic [DW-1:0] wr_data,
  input  logic          incr_pc,
  input  logic          cr_we,
  input  logic [DW-1:0] cr_wdata,
  output logic [DW-1:0] cr_rdata,
  input  logic          trap_req,
  input  logic          rti,
  output logic [BW-1:0] cur_bank,
  output logic [DW-1:0] pc
);

  localparam logic [BW-1:0] SYS_BANK = BW'(NBANK - 1);
  localparam logic [AW-1:0] PC_SEL   = AW'(PC_IDX);
  localparam logic [AW-1:0] SAVE_SEL = AW'(1);

  // The operating mode is fully determined by the active bank.
  typedef enum logic {
    MODE_USER = 1'b0,
    MODE_SYS  = 1'b1
  } mode_e;

  logic [DW-1:0] regFile [NBANK][NREG];
  logic [DW-1:0] crReg   [NBANK];
  logic [BW-1:0] curBank;
  logic [BW-1:0] prvBank;
  mode_e         mode;
  logic          pcWritten;

  // Decode the current mode from the active bank.
  always_comb begin
    mode = MODE_USER;
    if (curBank == SYS_BANK) begin
      mode = MODE_SYS;
    end else begin
      mode = MODE_USER;
    end
  end

  // A direct write to the PC register takes precedence over auto-increment.
  always_comb begin
    pcWritten = 1'b0;
    if (wr_en && (wr_sel == PC_SEL)) begin
      pcWritten = 1'b1;
    end else begin
      pcWritten = 1'b0;
    end
  end

  // Bank state: trap entry has priority over rti, which has priority over normal writes.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NBANK; b++) begin
        for (int r = 0; r < NREG; r++) begin
          regFile[b][r] <= '0;
        end
        crReg[b] <= (b == NBANK - 1) ? SCR_INIT : CR_INIT;
      end
      regFile[SYS_BANK][PC_SEL] <= IVEC;
      curBank <= SYS_BANK;
      prvBank <= '0;
    end else begin
      case (mode)
        MODE_USER: begin
          if (trap_req) begin
            // Save the interrupted PC as it was before any increment this edge.
            prvBank                     <= curBank;
            curBank                     <= SYS_BANK;
            regFile[SYS_BANK][SAVE_SEL] <= regFile[curBank][PC_SEL];
            regFile[SYS_BANK][PC_SEL]   <= IVEC;
          end else begin
            // rti outside the system bank is a no-op; normal processing applies.
            if (wr_en && (wr_sel != '0)) begin
              regFile[curBank][wr_sel] <= wr_data;
            end
            if (incr_pc && !pcWritten) begin
              regFile[curBank][PC_SEL] <= regFile[curBank][PC_SEL] + DW'(PC_INC);
            end
            if (cr_we) begin
              crReg[curBank] <= cr_wdata;
            end
          end
        end
        MODE_SYS: begin
          // No trap nesting: trap_req here falls through to rti/normal handling.
          if (rti) begin
            curBank <= prvBank;
          end else begin
            if (wr_en && (wr_sel != '0)) begin
              regFile[curBank][wr_sel] <= wr_data;
            end
            if (incr_pc && !pcWritten) begin
              regFile[curBank][PC_SEL] <= regFile[curBank][PC_SEL] + DW'(PC_INC);
            end
            if (cr_we) begin
              crReg[curBank] <= cr_wdata;
            end
          end
        end
        default: begin
          curBank <= SYS_BANK;
        end
      endcase
    end
  end

  // Combinational read ports from the active bank; index 0 is hardwired zero.
  always_comb begin
    rd0_data = '0;
    rd1_data = '0;
    if (rd0_sel != '0) begin
      rd0_data = regFile[curBank][rd0_sel];
    end else begin
      rd0_data = '0;
    end
    if (rd1_sel != '0) begin
      rd1_data = regFile[curBank][rd1_sel];
    end else begin
      rd1_data = '0;
    end
  end

  assign cr_rdata = crReg[curBank];
  assign pc       = regFile[curBank][PC_SEL];
  assign cur_bank = curBank;

endmodule
